// File: rtl/gba_io_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gba_io_arb_pkg
// Description : Shared types and default constants for the frame-buffer
//               access arbiter (cart bus vs. USB host bridge).
// Revision    : 1.0 - initial release
// ============================================================================
package gba_io_arb_pkg;

   // Default configuration constants
   localparam int ARB_ADDR_W           = 26;
   localparam int ARB_USB_MAX_BURST    = 64;
   localparam int ARB_USB_STARVE_LIMIT = 16;
   localparam int ARB_TURNAROUND       = 1;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CART = 2'd1,
      ST_USB  = 2'd2,
      ST_TURN = 2'd3
   } arb_state_e;

   // Source of the beat accepted in the current cycle
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CART = 2'd1,
      OWN_USB  = 2'd2
   } arb_owner_e;

endpackage
`default_nettype wire

// File: rtl/arb_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : arb_sat_counter
// Description : Up-counter with synchronous clear and enable that sticks at
//               MAX instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_sat_counter #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   // Clear has priority over counting; counting stops at MAX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != MAX)) begin
         count <= count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/buffer_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : buffer_access_arbiter
// Description : Grants the shared frame-buffer translator port to either the
//               cart bus or the USB bridge, one owner at a time, with a USB
//               burst cap, cart preemption of USB and a USB starvation guard.
//               Optional statistics outputs: BUFFER_ACCESS_ARBITER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_access_arbiter
   import gba_io_arb_pkg::*;
#(
   parameter int ADDR_W           = ARB_ADDR_W,
   parameter int USB_MAX_BURST    = ARB_USB_MAX_BURST,
   parameter int USB_STARVE_LIMIT = ARB_USB_STARVE_LIMIT,
   parameter int TURNAROUND       = ARB_TURNAROUND
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cart_req,
   input  logic [ADDR_W-1:0] cart_addr,
   input  logic              cart_last,
   output logic              cart_gnt,
   input  logic              usb_req,
   input  logic [ADDR_W-1:0] usb_addr,
   input  logic              usb_last,
   output logic              usb_gnt,
   output logic              from_cart,
   output logic              from_usb,
   output logic [ADDR_W-1:0] cart_usb_addr,
   output logic              busy
`ifdef BUFFER_ACCESS_ARBITER_STATS_EN
   ,
   output logic [31:0]       cart_beats,
   output logic [31:0]       usb_beats,
   output logic [15:0]       preempt_cnt
`endif
);

   localparam int BW = $clog2(USB_MAX_BURST + 1);
   localparam int SW = $clog2(USB_STARVE_LIMIT + 1);
   localparam logic [BW-1:0] BEAT_LAST   = BW'(USB_MAX_BURST - 1);
   localparam logic [SW-1:0] STARVE_FULL = SW'(USB_STARVE_LIMIT);
   localparam logic [2:0]    TURN_LAST   = 3'(TURNAROUND - 1);

   arb_state_e  state;
   arb_state_e  state_nxt;
   arb_owner_e  acc_owner;
   logic [BW-1:0] beat_cnt;
   logic [SW-1:0] starve_cnt;
   logic [2:0]  turn_cnt;
   logic        starve_pri;
   logic        cart_acc;
   logic        usb_acc;
   logic        starve_hit;
   logic        usb_enter;
   logic        preempt;
   logic        usb_done;

   assign cart_gnt   = (state == ST_CART);
   assign usb_gnt    = (state == ST_USB);
   assign busy       = (state != ST_IDLE);
   assign cart_acc   = cart_req && cart_gnt;
   assign usb_acc    = usb_req && usb_gnt;
   assign starve_hit = (starve_cnt == STARVE_FULL);
   assign usb_enter  = (state == ST_IDLE) && (state_nxt == ST_USB);
   assign preempt    = usb_gnt && cart_req && !starve_pri;
   // The cap check looks at the pre-increment count, so the burst ends on
   // the edge that accepts beat number USB_MAX_BURST
   assign usb_done   = usb_acc && (usb_last || (beat_cnt == BEAT_LAST));

   // Next-state selection; a starved USB outranks cart only in IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (usb_req && starve_hit) state_nxt = ST_USB;
            else if (cart_req)         state_nxt = ST_CART;
            else if (usb_req)          state_nxt = ST_USB;
         end
         ST_CART: if (cart_acc && cart_last)  state_nxt = ST_TURN;
         ST_USB:  if (usb_done || preempt)    state_nxt = ST_TURN;
         ST_TURN: if (turn_cnt == TURN_LAST)  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Identify which requester (if any) hands over a beat this cycle
   always_comb begin
      acc_owner = OWN_NONE;
      if (cart_acc)     acc_owner = OWN_CART;
      else if (usb_acc) acc_owner = OWN_USB;
   end

   // State, turnaround timer and starvation-priority latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         turn_cnt   <= 3'd0;
         starve_pri <= 1'b0;
      end else begin
         state    <= state_nxt;
         turn_cnt <= ((state == ST_TURN) && (state_nxt == ST_TURN)) ? turn_cnt + 3'd1 : 3'd0;
         if (usb_enter) begin
            starve_pri <= starve_hit;
         end
      end
   end

   // Registered translator strobes; address holds between strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         from_cart     <= 1'b0;
         from_usb      <= 1'b0;
         cart_usb_addr <= '0;
      end else begin
         from_cart <= (acc_owner == OWN_CART);
         from_usb  <= (acc_owner == OWN_USB);
         case (acc_owner)
            OWN_CART: cart_usb_addr <= cart_addr;
            OWN_USB:  cart_usb_addr <= usb_addr;
            default:  cart_usb_addr <= cart_usb_addr;
         endcase
      end
   end

   arb_sat_counter #(
      .WIDTH (BW),
      .MAX   (BW'(USB_MAX_BURST))
   ) u_beat_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (usb_enter),
      .en    (usb_acc),
      .count (beat_cnt)
   );

   arb_sat_counter #(
      .WIDTH (SW),
      .MAX   (STARVE_FULL)
   ) u_starve_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (usb_enter),
      .en    (usb_req && !usb_gnt),
      .count (starve_cnt)
   );

`ifdef BUFFER_ACCESS_ARBITER_STATS_EN
   arb_sat_counter #(.WIDTH(32)) u_cart_beats (
      .clk (clk), .rst_n (rst_n), .clr (1'b0), .en (cart_acc), .count (cart_beats)
   );

   arb_sat_counter #(.WIDTH(32)) u_usb_beats (
      .clk (clk), .rst_n (rst_n), .clr (1'b0), .en (usb_acc), .count (usb_beats)
   );

   // A burst that was ending anyway is not counted as preempted
   arb_sat_counter #(.WIDTH(16)) u_preempt_cnt (
      .clk (clk), .rst_n (rst_n), .clr (1'b0), .en (preempt && !usb_done), .count (preempt_cnt)
   );
`endif

endmodule
`default_nettype wire

// File: tb/tb_buffer_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer_access_arbiter
// Description : Self-checking bench for buffer_access_arbiter. Bench-side
//               requester models push expected strobes into a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer_access_arbiter;

   localparam int ADDR_W = 26;
   localparam int MAXB   = 64;
   localparam int STARVE = 16;
   localparam int TA     = 1;

   typedef struct packed {
      logic              is_usb;
      logic [ADDR_W-1:0] addr;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cart_req = 1'b0;
   logic [ADDR_W-1:0] cart_addr = '0;
   logic              cart_last = 1'b0;
   logic              usb_req = 1'b0;
   logic [ADDR_W-1:0] usb_addr = '0;
   logic              usb_last = 1'b0;
   logic              cart_gnt;
   logic              usb_gnt;
   logic              from_cart;
   logic              from_usb;
   logic [ADDR_W-1:0] cart_usb_addr;
   logic              busy;
`ifdef BUFFER_ACCESS_ARBITER_STATS_EN
   logic [31:0]       cart_beats;
   logic [31:0]       usb_beats;
   logic [15:0]       preempt_cnt;
`endif

   buffer_access_arbiter #(
      .ADDR_W           (ADDR_W),
      .USB_MAX_BURST    (MAXB),
      .USB_STARVE_LIMIT (STARVE),
      .TURNAROUND       (TA)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cart_req      (cart_req),
      .cart_addr     (cart_addr),
      .cart_last     (cart_last),
      .cart_gnt      (cart_gnt),
      .usb_req       (usb_req),
      .usb_addr      (usb_addr),
      .usb_last      (usb_last),
      .usb_gnt       (usb_gnt),
      .from_cart     (from_cart),
      .from_usb      (from_usb),
      .cart_usb_addr (cart_usb_addr),
      .busy          (busy)
`ifdef BUFFER_ACCESS_ARBITER_STATS_EN
      ,
      .cart_beats    (cart_beats),
      .usb_beats     (usb_beats),
      .preempt_cnt   (preempt_cnt)
`endif
   );

   always #5 clk = ~clk;

   int    n_cmp = 0;
   int    n_bad = 0;
   beat_t sb_q[$];
   int    seg_q[$];
   int    c_left, u_left;
   bit    c_single;
   int    cyc, n_cs, n_us, n_ua, usb_rises, first_usb_cyc, cart_before_usb, cur_seg;
   logic  prev_ugnt;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic clear_stats();
      sb_q.delete();
      seg_q.delete();
      cyc = 0; n_cs = 0; n_us = 0; n_ua = 0;
      usb_rises = 0; first_usb_cyc = -1; cart_before_usb = 0; cur_seg = 0;
      prev_ugnt = 1'b0;
   endtask

   // Leaves the bench at cycle 0: #1 after an edge with the DUT idle
   task automatic reset_dut();
      rst_n = 1'b0;
      cart_req = 1'b0; cart_last = 1'b0; usb_req = 1'b0; usb_last = 1'b0;
      c_single = 1'b0; c_left = 0; u_left = 0;
      clear_stats();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic start_cart(input int n, input logic [ADDR_W-1:0] a, input bit single);
      cart_addr = a; c_left = n; c_single = single;
      cart_req  = 1'b1;
      cart_last = single || (n == 1);
   endtask

   task automatic start_usb(input int n, input logic [ADDR_W-1:0] a);
      usb_addr = a; u_left = n;
      usb_req  = 1'b1;
      usb_last = (n == 1);
   endtask

   // One clock: predict accepts, check strobes against the scoreboard,
   // then advance the requester models
   task automatic cycle();
      logic  c_acc, u_acc;
      bit    pushed;
      beat_t e;
      @(negedge clk);
      c_acc  = cart_req && cart_gnt;
      u_acc  = usb_req && usb_gnt;
      pushed = 1'b0;
      check("one_gnt", 64'(cart_gnt & usb_gnt), 64'd0);
      if (c_acc) begin sb_q.push_back(beat_t'{1'b0, cart_addr}); pushed = 1'b1; end
      if (u_acc) begin sb_q.push_back(beat_t'{1'b1, usb_addr});  pushed = 1'b1; end
      @(posedge clk);
      #1;
      cyc++;
      check("strobe_time", 64'(from_cart | from_usb), 64'(pushed));
      if (from_cart || from_usb) begin
         if (from_cart) n_cs++;
         if (from_usb)  n_us++;
         if (sb_q.size() == 0) begin
            check("spurious_strobe", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("strobe_src", 64'({from_usb, from_cart}), e.is_usb ? 64'd2 : 64'd1);
            check("strobe_addr", 64'(cart_usb_addr), 64'(e.addr));
         end
      end
      if (usb_gnt && !prev_ugnt) begin
         usb_rises++;
         if (first_usb_cyc < 0) first_usb_cyc = cyc;
      end
      if (u_acc) cur_seg++;
      if (!usb_gnt && prev_ugnt) begin
         seg_q.push_back(cur_seg);
         cur_seg = 0;
      end
      prev_ugnt = usb_gnt;
      if (c_acc) begin
         if (first_usb_cyc < 0) cart_before_usb++;
         cart_addr = cart_addr + 26'd2;
         if (!c_single) begin
            c_left--;
            cart_req  = (c_left > 0);
            cart_last = (c_left == 1);
         end
      end
      if (u_acc) begin
         n_ua++;
         usb_addr = usb_addr + 26'd2;
         u_left--;
         usb_req  = (u_left > 0);
         usb_last = (u_left == 1);
      end
   endtask

   task automatic run_until(input int cs, input int us, input int budget, input string tag);
      while (!((n_cs >= cs) && (n_us >= us) && !busy) && (cyc < budget)) cycle();
      if (cyc >= budget) check({tag, "_timeout"}, 64'd1, 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  drop_cyc;
      int  cart_rise;
      bit  cart_started;
      bit  chk_drop;

      // ---------------- reset state ----------------
      clear_stats();
      #2;
      check("rst_cart_gnt", 64'(cart_gnt), 64'd0);
      check("rst_usb_gnt", 64'(usb_gnt), 64'd0);
      check("rst_strobes", 64'({from_cart, from_usb}), 64'd0);
      check("rst_addr", 64'(cart_usb_addr), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);

      // ---------------- cart only ----------------
      reset_dut();
      start_cart(3, 26'h1000000, 1'b0);
      cycle();
      check("co_cart_gnt_c1", 64'(cart_gnt), 64'd1);
      check("co_usb_gnt_c1", 64'(usb_gnt), 64'd0);
      repeat (3) cycle();
      check("co_busy_turn", 64'(busy), 64'd1);
      check("co_gnt_turn", 64'(cart_gnt), 64'd0);
      repeat (TA) cycle();
      check("co_busy_idle", 64'(busy), 64'd0);
      check("co_cart_total", 64'(n_cs), 64'd3);
      check("co_sb_empty", 64'(sb_q.size()), 64'd0);

      // ---------------- preemption ----------------
      reset_dut();
      start_usb(10, 26'h2000000);
      cart_started = 1'b0; chk_drop = 1'b0; drop_cyc = 0; cart_rise = -1;
      while (!((n_us >= 10) && (n_cs >= 2) && !busy) && (cyc < 200)) begin
         cycle();
         if (chk_drop) begin
            check("pre_usb_gnt_drop", 64'(usb_gnt), 64'd0);
            drop_cyc = cyc;
            chk_drop = 1'b0;
         end
         if (cart_started && (cart_rise < 0) && cart_gnt) cart_rise = cyc;
         if (!cart_started && (n_ua == 4)) begin
            start_cart(2, 26'h1000100, 1'b0);
            cart_started = 1'b1;
            chk_drop = 1'b1;
         end
      end
      if (cyc >= 200) check("pre_timeout", 64'd1, 64'd0);
      check("pre_usb_total", 64'(n_us), 64'd10);
      check("pre_cart_total", 64'(n_cs), 64'd2);
      check("pre_usb_grants", 64'(usb_rises), 64'd2);
      // TURN for TA cycles, one IDLE decision cycle, then cart owns the port
      check("pre_cart_latency", 64'(cart_rise - drop_cyc), 64'(1 + TA));
      check("pre_seg_count", 64'(seg_q.size()), 64'd2);
      // the beat offered on the preempting edge is still taken
      if (seg_q.size() == 2) begin
         check("pre_seg0", 64'(seg_q[0]), 64'd5);
         check("pre_seg1", 64'(seg_q[1]), 64'd5);
      end

      // ---------------- starvation ----------------
      reset_dut();
      start_usb(3, 26'h3000000);
      start_cart(1, 26'h1000200, 1'b1);
      while ((n_us < 3) && (cyc < 200)) cycle();
      if (cyc >= 200) check("stv_timeout", 64'd1, 64'd0);
      // cart cycles IDLE/CART/TURN every 3 edges; the IDLE edge at cycle 18
      // is the first to see starve_cnt at 16, so USB owns the port at 19
      check("stv_first_usb", 64'(first_usb_cyc), 64'd19);
      check("stv_cart_beats", 64'(cart_before_usb), 64'd6);
      check("stv_usb_grants", 64'(usb_rises), 64'd1);
      check("stv_cart_req_held", 64'(cart_req), 64'd1);
      if (seg_q.size() > 0) check("stv_seg0", 64'(seg_q[0]), 64'd3);
      else check("stv_seg_count", 64'd0, 64'd1);

      // ---------------- burst cap ----------------
      reset_dut();
      start_usb(100, 26'h0100000);
      run_until(0, 100, 400, "cap");
      check("cap_usb_total", 64'(n_us), 64'd100);
      check("cap_usb_grants", 64'(usb_rises), 64'd2);
      check("cap_seg_count", 64'(seg_q.size()), 64'd2);
      if (seg_q.size() == 2) begin
         check("cap_seg0", 64'(seg_q[0]), 64'(MAXB));
         check("cap_seg1", 64'(seg_q[1]), 64'(100 - MAXB));
      end

      // ---------------- simultaneous request ----------------
      reset_dut();
      start_cart(2, 26'h1000300, 1'b0);
      start_usb(2, 26'h2000300);
      cycle();
      check("sim_cart_first", 64'(cart_gnt), 64'd1);
      check("sim_usb_wait", 64'(usb_gnt), 64'd0);
      run_until(2, 2, 100, "sim");
      check("sim_cart_total", 64'(n_cs), 64'd2);
      check("sim_usb_total", 64'(n_us), 64'd2);
      check("sim_sb_empty", 64'(sb_q.size()), 64'd0);

      // ---------------- async reset mid-burst ----------------
      reset_dut();
      start_cart(5, 26'h1000400, 1'b0);
      repeat (3) cycle();
      check("ar_strobe_before", 64'(from_cart), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_cart_gnt", 64'(cart_gnt), 64'd0);
      check("ar_strobes", 64'({from_cart, from_usb}), 64'd0);
      check("ar_addr", 64'(cart_usb_addr), 64'd0);
      check("ar_busy", 64'(busy), 64'd0);
      cart_req = 1'b0; cart_last = 1'b0;
      sb_q.delete();
      prev_ugnt = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) cycle();
      check("ar_busy_after", 64'(busy), 64'd0);
      check("ar_no_residual", 64'(n_cs), 64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
